// File: rtl/fifo_word_reader_if.sv
// Signal bundle between fifo_word_reader, the simple_fifo read port and the word-wide consumer.
// Stream: a word moves when out_valid && out_ready at posedge; out_data/out_bytes hold while out_valid && !out_ready.
interface fifo_word_reader_if #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
);
    localparam int OUT_WIDTH = WIDTH * COUNT;
    localparam int BYTES_W   = $clog2(COUNT + 1);

    logic                 fifo_rd;
    logic [WIDTH-1:0]     fifo_rdata;
    logic                 fifo_rvalid;
    logic                 fifo_not_empty;
    logic [OUT_WIDTH-1:0] out_data;
    logic [BYTES_W-1:0]   out_bytes;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output fifo_rd, out_data, out_bytes, out_valid,
        input  fifo_rdata, fifo_rvalid, fifo_not_empty, out_ready
    );

    modport slave (
        input  fifo_rd, out_data, out_bytes, out_valid,
        output fifo_rdata, fifo_rvalid, fifo_not_empty, out_ready
    );
endinterface

// File: rtl/fifo_word_reader.sv
// Pulls WIDTH-bit entries out of simple_fifo and packs COUNT of them little-endian into one
// output word; a flush request pushes out whatever partial word has been gathered.
module fifo_word_reader #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic                clk,
    input  logic                reset,
    fifo_word_reader_if.master  bus,
    input  logic                flush,
    output logic                flush_busy,
    output logic                dbg_state_o
);
    localparam int OUT_WIDTH = WIDTH * COUNT;
    localparam int IDX_W     = $clog2(COUNT + 1);
    localparam int CMP_W     = IDX_W + 1;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic                           out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]           out_data_q, out_data_d;
    logic [IDX_W-1:0]               out_bytes_q, out_bytes_d;
    logic [COUNT-1:0][WIDTH-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           acc_full_q, acc_full_d;
    logic                           inflight_q;

    logic                           slot_free;
    logic                           rd_c;
    logic [CMP_W-1:0]               pending;
    logic [COUNT-1:0][WIDTH-1:0]    full_word;
    logic [COUNT-1:0][WIDTH-1:0]    partial_word;

    // Slots already claimed (landed + in flight) bound the reads so a word never over-fills.
    assign pending   = CMP_W'(idx_q) + CMP_W'(inflight_q);
    assign slot_free = !out_valid_q || bus.out_ready;
    assign rd_c      = !reset && bus.fifo_not_empty && (state_q == RUN) && !flush
                       && (pending < CMP_W'(COUNT)) && !acc_full_q;

    assign bus.fifo_rd   = rd_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_bytes = out_bytes_q;
    assign bus.out_valid = out_valid_q;
    assign flush_busy    = (state_q == FLUSH);
    assign dbg_state_o   = state_q;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_bytes_d  = out_bytes_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        acc_full_d   = acc_full_q;
        full_word    = acc_q;
        partial_word = '0;

        full_word[COUNT-1] = bus.fifo_rdata;
        for (int k = 0; k < COUNT; k++) begin
            if (IDX_W'(k) < idx_q) begin
                partial_word[k] = acc_q[k];
            end
        end

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (acc_full_q) begin
            // A completed word parked behind a stalled output moves out as soon as the slot frees.
            if (slot_free) begin
                out_data_d  = acc_q;
                out_bytes_d = IDX_W'(COUNT);
                out_valid_d = 1'b1;
                idx_d       = '0;
                acc_full_d  = 1'b0;
            end
        end else if (bus.fifo_rvalid) begin
            if (idx_q == IDX_W'(COUNT - 1)) begin
                if (slot_free) begin
                    out_data_d  = full_word;
                    out_bytes_d = IDX_W'(COUNT);
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                end else begin
                    acc_d[COUNT-1] = bus.fifo_rdata;
                    acc_full_d     = 1'b1;
                    idx_d          = IDX_W'(COUNT);
                end
            end else begin
                for (int k = 0; k < COUNT; k++) begin
                    if (IDX_W'(k) == idx_q) begin
                        acc_d[k] = bus.fifo_rdata;
                    end
                end
                idx_d = idx_q + 1'b1;
            end
        end

        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // No rvalid can arrive once inflight is clear, so the partial load cannot collide.
                if (!inflight_q && !acc_full_q) begin
                    if (idx_q == '0) begin
                        state_d = RUN;
                    end else if (slot_free) begin
                        out_data_d  = partial_word;
                        out_bytes_d = idx_q;
                        out_valid_d = 1'b1;
                        idx_d       = '0;
                        state_d     = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            acc_full_q  <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            acc_full_q  <= acc_full_d;
            inflight_q  <= rd_c;
        end
    end
endmodule

// File: tb/tb_fifo_word_reader.sv
// Bench for fifo_word_reader: a queue-based simple_fifo model feeds the reader and a
// scoreboard checks each accepted word against expectations pushed with the stimulus.
module tb_fifo_word_reader;
    localparam int WIDTH     = 8;
    localparam int COUNT     = 4;
    localparam int OUT_WIDTH = WIDTH * COUNT;
    localparam int BYTES_W   = $clog2(COUNT + 1);
    localparam int EXP_W     = BYTES_W + OUT_WIDTH;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic flush_busy;
    logic dbg_state;

    fifo_word_reader_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus ();

    fifo_word_reader #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .flush       (flush),
        .flush_busy  (flush_busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;

    logic [EXP_W-1:0] exp_q[$];
    int               acc_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- simple_fifo model ----------------
    logic [WIDTH-1:0] fifo_q[$];
    logic             fifo_wr;
    logic [WIDTH-1:0] fifo_wdata;
    int               fifo_cnt = 0;
    logic             rd_s = 1'b0;

    assign bus.fifo_not_empty = (fifo_cnt != 0);

    always @(posedge clk) begin
        if (reset) begin
            fifo_q.delete();
            bus.fifo_rvalid <= 1'b0;
            bus.fifo_rdata  <= '0;
        end else begin
            if (rd_s && fifo_q.size() > 0) begin
                bus.fifo_rdata  <= fifo_q.pop_front();
                bus.fifo_rvalid <= 1'b1;
            end else begin
                bus.fifo_rvalid <= 1'b0;
            end
            if (fifo_wr) fifo_q.push_back(fifo_wdata);
        end
        fifo_cnt <= fifo_q.size();
    end

    // ---------------- monitor / scoreboard ----------------
    logic             hold_prev = 1'b0;
    logic [EXP_W-1:0] hold_word = '0;

    always @(negedge clk) begin
        rd_s = bus.fifo_rd;
        if (!reset) begin
            if (bus.fifo_rd) begin
                rd_cnt++;
                check("rd_guard_not_empty", 64'(bus.fifo_not_empty), 64'(1));
            end
            if (hold_prev) check("hold_stable", 64'({bus.out_bytes, bus.out_data}), 64'(hold_word));
            if (bus.out_valid && bus.out_ready) begin
                acc_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("spurious_word_valid", 64'(bus.out_valid), 64'(0));
                end else begin
                    check("word", 64'({bus.out_bytes, bus.out_data}), 64'(exp_q.pop_front()));
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_word = {bus.out_bytes, bus.out_data};
        end else begin
            hold_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_entry(input logic [WIDTH-1:0] d);
        fifo_wr    = 1'b1;
        fifo_wdata = d;
        tick();
        fifo_wr    = 1'b0;
    endtask

    task automatic expect_word(input int bytes, input logic [OUT_WIDTH-1:0] data);
        exp_q.push_back({BYTES_W'(bytes), data});
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int max_gap;
        reset         = 1'b1;
        flush         = 1'b0;
        fifo_wr       = 1'b0;
        fifo_wdata    = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_bytes", 64'(bus.out_bytes), 64'(0));
        check("rst_flush_busy", 64'(flush_busy), 64'(0));
        check("rst_fifo_rd", 64'(bus.fifo_rd), 64'(0));
        reset = 1'b0;
        tick();

        // Full word straight through
        bus.out_ready = 1'b1;
        rd_cnt = 0;
        expect_word(4, 32'h44332211);
        wr_entry(8'h11); wr_entry(8'h22); wr_entry(8'h33); wr_entry(8'h44);
        wait_drain(30);
        repeat (3) tick();
        check("t1_rd_count", 64'(rd_cnt), 64'(4));

        // Output stalled: second word parks in the accumulator
        bus.out_ready = 1'b0;
        expect_word(4, 32'h04030201);
        expect_word(4, 32'h08070605);
        for (int i = 1; i <= 8; i++) wr_entry(WIDTH'(i));
        repeat (12) tick();
        @(negedge clk);
        check("t2_valid_held", 64'(bus.out_valid), 64'(1));
        check("t2_first_word", 64'(bus.out_data), 64'(32'h04030201));
        check("t2_rd_idle", 64'(bus.fifo_rd), 64'(0));
        check("t2_fifo_consumed", 64'(fifo_q.size()), 64'(0));
        tick();
        acc_cyc_q.delete();
        bus.out_ready = 1'b1;
        wait_drain(20);
        check("t2_accepts", 64'(acc_cyc_q.size()), 64'(2));
        if (acc_cyc_q.size() == 2) check("t2_back_to_back", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'(1));

        // Partial flush, then flush with nothing gathered
        wr_entry(8'haa); wr_entry(8'hbb); wr_entry(8'hcc);
        repeat (6) tick();
        expect_word(3, 32'h00ccbbaa);
        pulse_flush();
        @(negedge clk);
        check("t3_busy", 64'(flush_busy), 64'(1));
        check("t3_state", 64'(dbg_state), 64'(1));
        wait_drain(20);
        repeat (2) tick();
        check("t3_busy_clear", 64'(flush_busy), 64'(0));
        pulse_flush();
        @(negedge clk);
        check("t3_empty_busy", 64'(flush_busy), 64'(1));
        tick();
        @(negedge clk);
        check("t3_empty_busy_clear", 64'(flush_busy), 64'(0));
        repeat (4) tick();
        check("t3_no_word", 64'(acc_cyc_q.size()), 64'(3));

        // Flush while the second entry is still in flight
        wr_entry(8'h11); wr_entry(8'h22);
        tick();
        check("t4_entry_in_flight", 64'(bus.fifo_rvalid), 64'(1));
        expect_word(2, 32'h00002211);
        pulse_flush();
        wait_drain(20);
        repeat (2) tick();

        // Reset with a pending word and a partial accumulator
        bus.out_ready = 1'b0;
        wr_entry(8'ha1); wr_entry(8'ha2); wr_entry(8'ha3); wr_entry(8'ha4);
        wr_entry(8'hb1); wr_entry(8'hb2);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_out_valid", 64'(bus.out_valid), 64'(0));
        check("t5_out_data", 64'(bus.out_data), 64'(0));
        check("t5_out_bytes", 64'(bus.out_bytes), 64'(0));
        check("t5_flush_busy", 64'(flush_busy), 64'(0));
        tick();
        bus.out_ready = 1'b1;
        expect_word(4, 32'h0d0c0b0a);
        wr_entry(8'h0a); wr_entry(8'h0b); wr_entry(8'h0c); wr_entry(8'h0d);
        wait_drain(30);

        // Continuous stream of ee
        acc_cyc_q.delete();
        for (int i = 0; i < 100; i++) begin
            if (i % COUNT == 0) expect_word(4, 32'heeeeeeee);
            wr_entry(8'hee);
        end
        wait_drain(200);
        check("t6_words", 64'(acc_cyc_q.size()), 64'(25));
        max_gap = 0;
        for (int i = 1; i < acc_cyc_q.size(); i++) begin
            if (acc_cyc_q[i] - acc_cyc_q[i-1] > max_gap) max_gap = acc_cyc_q[i] - acc_cyc_q[i-1];
        end
        check("t6_rate_gap_le5", 64'(max_gap <= 5), 64'(1));
        check("t6_fifo_consumed", 64'(fifo_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
